jbi_sc_req_tx: RTL
==================

// Module: jbi_sc_req_tx
// PURPOSE
//  JBI-side transmitter for the JBI->SCTAG request path. Takes queued requests (headers plus
//  write data) and serializes them as 32-bit words onto jbi_sctag_req / jbi_sctag_req_vld /
//  jbi_scbuf_ecc, toward the L2 pipeline flop stage.
//  Enforces SCTAG IQ and WIB credits, returned by sctag_jbi_iq_dequeue / sctag_jbi_wib_dequeue.
//  Blocks new packets while SCTAG raises sctag_jbi_por_req.
// PARAMETERS
//  IQ_CREDITS   16  SCTAG input-queue entries; one consumed per packet
//  WIB_CREDITS  4   SCTAG write-invalidate-buffer entries; one consumed per write packet
//  CNT_W        5   credit counter width; must hold IQ_CREDITS and WIB_CREDITS
// PORTS
//  rclk                   in   1   clock
//  rst_l                  in   1   asynchronous reset, active low
//  req_vld                in   1   upstream request pending; hold with req_type/req_hdr0/1 until req_ack
//  req_type               in   2   0=RD, 1=WR8 (2 data beats), 2=WRI (16 data beats), 3=reserved
//  req_hdr0               in   32  header word 0
//  req_hdr1               in   32  header word 1
//  req_ack                out  1   1-cycle pulse: header accepted, upstream pops request
//  wr_data                in   32  write data beat (first-word-fall-through FIFO head)
//  wr_ecc                 in   7   ECC for wr_data
//  wr_data_pop            out  1   pop FIFO head; beat captured into output flop this cycle
//  jbi_sctag_req          out  32  request word to SCTAG (registered)
//  jbi_sctag_req_vld      out  1   high on header word 0 only (registered)
//  jbi_scbuf_ecc          out  7   ECC for data beats, 0 on header words (registered)
//  sctag_jbi_iq_dequeue   in   1   one IQ credit returned
//  sctag_jbi_wib_dequeue  in   1   one WIB credit returned
//  sctag_jbi_por_req      in   1   SCTAG POR request; no new packet starts while high
//  credit_err             out  1   sticky: credit return with counter already at max
// BEHAVIOUR
//  - Reset (rst_l=0, async): state IDLE; all outputs 0.
//    iq_cnt=IQ_CREDITS, wib_cnt=WIB_CREDITS, credit_err=0.
//    Reset mid-packet aborts the packet. No resume.
//  - FSM: IDLE -> HDR0 -> HDR1 -> [DATA x N] -> GAP -> IDLE.
//    N=0 for RD, 2 for WR8, 16 for WRI. GAP is one mandatory idle bus cycle.
//  - Start condition, evaluated in IDLE:
//    req_vld & iq_cnt!=0 & ~sctag_jbi_por_req & req_type!=3,
//    and wib_cnt!=0 when req_type is WR8 or WRI.
//    On start, the next edge enters HDR0.
//  - HDR0 cycle: jbi_sctag_req=req_hdr0, vld=1, ecc=0, req_ack=1.
//    req_type and req_hdr1 are latched internally.
//  - HDR1 cycle: req=hdr1, vld=0, ecc=0.
//  - DATA cycles: req=wr_data, ecc=wr_ecc, vld=0. Words are back-to-back with no bubbles.
//    wr_data_pop is asserted in the cycle each beat is registered, i.e. one cycle before the beat
//    appears on jbi_sctag_req.
//    Upstream guarantees all N beats are resident before req_vld; the tx does not stall mid-packet.
//  - Bus reads 0 in IDLE and GAP. Start-to-vld latency: 1 cycle.
//    Packet length on bus: 2+N cycles; min spacing between vld pulses: 2+N+2 cycles.
//  - Credits:
//    - iq_cnt decrements on the start edge; wib_cnt decrements on start of WR8/WRI.
//    - Each *_dequeue pulse increments its counter by 1.
//    - Decrement and dequeue in the same cycle: counter unchanged.
//    - Dequeue while counter==max and no decrement: counter holds at max, credit_err set
//      (sticky until reset).
//    - Counters never go below 0; the start condition prevents it.
//  - sctag_jbi_por_req only gates starts. A packet already in progress completes.
//  - req_type=3 is never started. req_ack stays 0; upstream is responsible.
// TESTING
//  - Reset then RD hdr0=32'hA5A5_0001, hdr1=32'h0000_0040
//    -> vld=1 one cycle with A5A5_0001, next cycle 0000_0040;
//       req_ack pulses with vld; iq_cnt 16->15.
//  - WRI with 16 beats D0..D15 and ECC
//    -> 18 contiguous words, ecc=0 on headers and matches wr_ecc on beats, 16 pops;
//       wib_cnt 4->3; idle cycle before the next vld.
//  - Issue 4 WR8s with no wib_dequeue
//    -> 5th WR8 held (no ack); pulse wib_dequeue -> it starts 1 cycle after.
//       A RD queued behind still needs iq_cnt only.
//  - Exhaust 16 IQ credits; assert iq_dequeue in the same cycle as the next start
//    -> iq_cnt stays constant; extra dequeue at 16 -> credit_err=1 and count stays 16.
//  - Raise sctag_jbi_por_req in HDR1 of a WRI
//    -> packet completes all 18 words; no new start until por_req drops.
//  - Drop rst_l in DATA beat 5 -> outputs 0 immediately, credits reinit; no residual pops.

Source files
------------

// File: rtl/jbi_sc_req_tx.sv
// JBI -> SCTAG request transmitter.
// Serializes queued requests (two header words plus 0/2/16 write-data beats) onto
// the 32-bit SCTAG request bus, one mandatory idle cycle after every packet.
// Starts are gated by SCTAG IQ/WIB credits and by the SCTAG POR request.
// Once a packet starts it always runs to completion.
module jbi_sc_req_tx #(
    parameter int IQ_CREDITS  = 16,
    parameter int WIB_CREDITS = 4,
    parameter int CNT_W       = 5
) (
    input  logic        rclk,
    input  logic        rst_l,
    input  logic        req_vld,
    input  logic [1:0]  req_type,
    input  logic [31:0] req_hdr0,
    input  logic [31:0] req_hdr1,
    output logic        req_ack,
    input  logic [31:0] wr_data,
    input  logic [6:0]  wr_ecc,
    output logic        wr_data_pop,
    output logic [31:0] jbi_sctag_req,
    output logic        jbi_sctag_req_vld,
    output logic [6:0]  jbi_scbuf_ecc,
    input  logic        sctag_jbi_iq_dequeue,
    input  logic        sctag_jbi_wib_dequeue,
    input  logic        sctag_jbi_por_req,
    output logic        credit_err
);

    localparam logic [1:0] TYPE_RD   = 2'd0;
    localparam logic [1:0] TYPE_WR8  = 2'd1;
    localparam logic [1:0] TYPE_WRI  = 2'd2;
    localparam logic [1:0] TYPE_RSVD = 2'd3;

    localparam logic [CNT_W-1:0] IQ_MAX  = CNT_W'(IQ_CREDITS);
    localparam logic [CNT_W-1:0] WIB_MAX = CNT_W'(WIB_CREDITS);

    // State names what the bus is showing during the current cycle.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR0,
        ST_HDR1,
        ST_DATA,
        ST_GAP
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        type_q, type_d;
    logic [31:0]       hdr1_q, hdr1_d;
    logic [3:0]        beat_q, beat_d;
    logic [CNT_W-1:0]  iq_cnt_q, iq_cnt_d;
    logic [CNT_W-1:0]  wib_cnt_q, wib_cnt_d;
    logic              err_q, err_d;
    logic [31:0]       req_q, req_d;
    logic              vld_q, vld_d;
    logic [6:0]        ecc_q, ecc_d;
    logic              ack_q, ack_d;

    logic              is_wr_req;
    logic              start;
    logic              has_data;
    logic [3:0]        last_beat;

    // Credit counter step: a take and a give in the same cycle cancel; a give at max holds.
    function automatic logic [CNT_W-1:0] credit_next(input logic [CNT_W-1:0] cnt,
                                                     input logic             take,
                                                     input logic             give,
                                                     input logic [CNT_W-1:0] max);
        if (take && !give)
            return cnt - 1'b1;
        if (give && !take && (cnt != max))
            return cnt + 1'b1;
        return cnt;
    endfunction

    // A returned credit with nowhere to go means SCTAG returned more than it was given.
    function automatic logic credit_ovf(input logic [CNT_W-1:0] cnt,
                                        input logic             take,
                                        input logic             give,
                                        input logic [CNT_W-1:0] max);
        return give && !take && (cnt == max);
    endfunction

    // Start qualification and per-packet beat bookkeeping.
    always_comb begin
        is_wr_req = (req_type == TYPE_WR8) || (req_type == TYPE_WRI);
        start     = (state_q == ST_IDLE) && req_vld && (iq_cnt_q != '0) &&
                    !sctag_jbi_por_req && (req_type != TYPE_RSVD) &&
                    (!is_wr_req || (wib_cnt_q != '0));
        has_data  = (type_q != TYPE_RD);
        last_beat = (type_q == TYPE_WR8) ? 4'd1 : 4'd15;
    end

    // A beat is popped in the cycle it is loaded into the output register.
    assign wr_data_pop = ((state_q == ST_HDR1) && has_data) ||
                         ((state_q == ST_DATA) && (beat_q != last_beat));

    // Next state, next bus word and credit updates.
    always_comb begin
        state_d   = state_q;
        type_d    = type_q;
        hdr1_d    = hdr1_q;
        beat_d    = beat_q;
        req_d     = '0;
        vld_d     = 1'b0;
        ecc_d     = '0;
        ack_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_HDR0;
                    type_d  = req_type;
                    hdr1_d  = req_hdr1;
                    req_d   = req_hdr0;
                    vld_d   = 1'b1;
                    ack_d   = 1'b1;
                end
            end
            ST_HDR0: begin
                state_d = ST_HDR1;
                req_d   = hdr1_q;
            end
            ST_HDR1: begin
                if (has_data) begin
                    state_d = ST_DATA;
                    beat_d  = 4'd0;
                    req_d   = wr_data;
                    ecc_d   = wr_ecc;
                end else begin
                    state_d = ST_GAP;
                end
            end
            ST_DATA: begin
                if (beat_q != last_beat) begin
                    beat_d = beat_q + 4'd1;
                    req_d  = wr_data;
                    ecc_d  = wr_ecc;
                end else begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        iq_cnt_d  = credit_next(iq_cnt_q, start, sctag_jbi_iq_dequeue, IQ_MAX);
        wib_cnt_d = credit_next(wib_cnt_q, start && is_wr_req, sctag_jbi_wib_dequeue, WIB_MAX);
        err_d     = err_q ||
                    credit_ovf(iq_cnt_q, start, sctag_jbi_iq_dequeue, IQ_MAX) ||
                    credit_ovf(wib_cnt_q, start && is_wr_req, sctag_jbi_wib_dequeue, WIB_MAX);
    end

    // All state and registered outputs; reset aborts any packet in flight.
    always_ff @(posedge rclk or negedge rst_l) begin
        if (!rst_l) begin
            state_q   <= ST_IDLE;
            type_q    <= TYPE_RD;
            hdr1_q    <= '0;
            beat_q    <= '0;
            iq_cnt_q  <= IQ_MAX;
            wib_cnt_q <= WIB_MAX;
            err_q     <= 1'b0;
            req_q     <= '0;
            vld_q     <= 1'b0;
            ecc_q     <= '0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            type_q    <= type_d;
            hdr1_q    <= hdr1_d;
            beat_q    <= beat_d;
            iq_cnt_q  <= iq_cnt_d;
            wib_cnt_q <= wib_cnt_d;
            err_q     <= err_d;
            req_q     <= req_d;
            vld_q     <= vld_d;
            ecc_q     <= ecc_d;
            ack_q     <= ack_d;
        end
    end

    assign jbi_sctag_req     = req_q;
    assign jbi_sctag_req_vld = vld_q;
    assign jbi_scbuf_ecc     = ecc_q;
    assign req_ack           = ack_q;
    assign credit_err        = err_q;

endmodule
